sprom_arbiter: RTL and testbench
================================

# sprom_arbiter

- Round-robin read arbiter that shares one SPROM instance between NUM_REQ independent requesters.
- Each requester holds a request with an address. The arbiter grants at most one requester per cycle and drives the ROM read address.
- It tracks each in-flight read through the ROM's 1- or 2-cycle latency, then returns the data to the owning requester with a valid pulse.
- It sits directly in front of SPROM in audio coefficient/table lookup paths where several filter or oscillator engines read one table.

## Interface
- DATA_WIDTH, 16: ROM word width; must match the attached SPROM.
- ADDR_WIDTH, 8: ROM address width; must match SPROM.
- OUTPUT_REG, "FALSE": must match SPROM. "FALSE" gives read latency L=1; "TRUE" gives L=2.
- NUM_REQ, 4: number of requesters, 2..8.

- CLK_I  in  1  clock; all state updates on the rising edge.
- RST_I  in  1  asynchronous active-high reset.
- REQ_I  in  NUM_REQ  per-requester read request; held high with a stable address until acknowledged.
- ADDR_I  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ACK_O  out  NUM_REQ  one-hot grant, combinational. High means the request is accepted at this rising edge.
- VALID_O  out  NUM_REQ  one-hot registered return strobe; one cycle per accepted read.
- DATA_O  out  DATA_WIDTH  read data. Equals ROM_RDATA_I, and is meaningful only while VALID_O is nonzero.
- ROM_RADDR_O  out  ADDR_WIDTH  to SPROM RADDR_I.
- ROM_RDATA_I  in  DATA_WIDTH  from SPROM RDATA_O.
- BUSY_O  out  1  high while any read is in flight (tag pipeline non-empty).

## Operation
**Grant selection**
- Round-robin pointer PTR (0..NUM_REQ-1) names the highest-priority requester. PTR resets to 0.
- Each cycle, the arbiter picks the first i with REQ_I[i]=1, scanning PTR, PTR+1, … modulo NUM_REQ.
- It asserts ACK_O[i] only.
- It drives ROM_RADDR_O from ADDR_I slice i.

**After each grant**
- On the edge, PTR becomes (i+1) mod NUM_REQ. PTR is unchanged when no grant is made.

**Idle and handshake**
- With no request, ACK_O=0 and ROM_RADDR_O=0.
- A request with REQ_I high at an edge where ACK_O is high counts as exactly one read.
- A requester wanting consecutive reads keeps REQ_I high and may change ADDR_I after each ACK.

**Tag pipeline**
- The pipeline is L stages deep. Each stage holds a valid bit and a requester index.
- Stage 0 captures the grant (valid=any ACK_O, index=i) on every edge.
- Stages shift each edge.
- The last stage drives VALID_O as a one-hot registered output, timed to coincide with the ROM data for that read.

**Throughput and ordering**
- One grant per cycle; no bubbles.
- Returns are in grant order.
- No back-pressure on returns: requesters must accept VALID_O whenever it fires.

**Reset (RST_I high, any time)**
- PTR=0; all tag stages invalid; VALID_O=0; BUSY_O=0.
- ACK_O is forced to 0 while RST_I is high.
- In-flight reads are discarded: no VALID_O is ever produced for a grant made before the reset.

## Timing
**Read latency and back-to-back grants**
- A grant at edge t produces VALID_O high in the cycle following edge t+L-1: 1 cycle after the grant cycle for L=1, 2 cycles for L=2.
- Back-to-back grants give back-to-back VALID_O pulses, one cycle each, to the respective requesters.

**BUSY_O**
- BUSY_O is the OR of tag-stage valids. It is registered-derived and never combinational from REQ_I.

**Boundary cases**
- All NUM_REQ requesting continuously gives strict rotation 0,1,…,NUM_REQ-1,0…; each requester gets exactly 1 of every NUM_REQ grants.
- PTR wrap: a grant to NUM_REQ-1 sets PTR=0.
- A request deasserted before it is granted is simply dropped; no state is retained.

## Test plan
Bench SPROM uses the standard init image word[a] = 0x00FF - a.

- **Single requester, L=1.** Requester 2 only, addresses 0,1,2 on consecutive ACKs -> ACK_O=4'b0100 each cycle; VALID_O[2] one cycle later; DATA_O = 0x00FF, 0x00FE, 0x00FD.
- **Full contention.** All four request continuously, requester i using address i -> grants rotate 0,1,2,3,0…; VALID_O one-hot follows the same order; DATA_O = 0x00FF - i.
- **Pointer rotation.** Requester 3 granted, then requesters 0 and 3 both request -> requester 0 granted first (PTR=0 after wrap).
- **OUTPUT_REG="TRUE".** Repeat scenario 1 -> VALID_O and data arrive 2 cycles after the grant cycle; BUSY_O high for 2 cycles after the last grant.
- **Reset mid-flight (L=2).** Pulse RST_I one cycle after a grant to requester 1 -> no VALID_O pulse for that read; PTR=0; VALID_O=0 and BUSY_O=0 immediately on RST_I assertion.
- **Idle and throughput.** REQ_I=0 for 10 cycles -> ACK_O=0, ROM_RADDR_O=0, BUSY_O=0. Then 320 consecutive grants -> exactly 320 VALID_O pulses with no gap, and addresses wrap 0xFF->0x00 correctly.

Source files
------------

// File: rtl/sprom_arbiter_if.sv
// Bus bundle between the requester side, the arbiter and the attached SPROM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sprom_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            REQ_I;
  logic [NUM_REQ*ADDR_WIDTH-1:0] ADDR_I;
  logic [NUM_REQ-1:0]            ACK_O;
  logic [NUM_REQ-1:0]            VALID_O;
  logic [DATA_WIDTH-1:0]         DATA_O;
  logic [ADDR_WIDTH-1:0]         ROM_RADDR_O;
  logic [DATA_WIDTH-1:0]         ROM_RDATA_I;
  logic                          BUSY_O;

  modport slave (
    input  REQ_I, ADDR_I, ROM_RDATA_I,
    output ACK_O, VALID_O, DATA_O, ROM_RADDR_O, BUSY_O
  );

  modport master (
    output REQ_I, ADDR_I, ROM_RDATA_I,
    input  ACK_O, VALID_O, DATA_O, ROM_RADDR_O, BUSY_O
  );
endinterface

// File: rtl/sprom_arbiter.sv
// Round-robin read arbiter sharing one SPROM between NUM_REQ requesters.
// A tag pipeline matching the ROM latency routes each returned word to its owner.
module sprom_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       OUTPUT_REG = "FALSE",
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  sprom_arbiter_if.slave bus
);

  // ROM read latency: address registered inside SPROM, plus optional output register.
  localparam int unsigned Lat  = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [Lat-1:0]  vld_q, vld_d;
  logic [IdxW-1:0] idx_q [Lat];
  logic [IdxW-1:0] idx_d [Lat];

  logic            gnt;
  logic [IdxW-1:0] gnt_idx;

  // Scan requesters starting at the pointer; first one found wins.
  always_comb begin
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;
    logic            found;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      sum = {1'b0, ptr_q} + (IdxW + 1)'(k);
      if (sum >= (IdxW + 1)'(NUM_REQ)) begin
        sum = sum - (IdxW + 1)'(NUM_REQ);
      end
      cand = sum[IdxW-1:0];
      if (!found && bus.REQ_I[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    // No grant may be issued while reset is held.
    gnt = found && !RST_I;
  end

  // Grant strobes and ROM address mux; address is zero when idle.
  always_comb begin
    bus.ACK_O       = '0;
    bus.ROM_RADDR_O = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt && (gnt_idx == IdxW'(i))) begin
        bus.ACK_O[i]    = 1'b1;
        bus.ROM_RADDR_O = bus.ADDR_I[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Next pointer and tag pipeline shift.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt) begin
      ptr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
    vld_d[0] = gnt;
    idx_d[0] = gnt_idx;
    for (int s = 1; s < int'(Lat); s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end

  // State registers; reset discards all in-flight reads.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ptr_q <= '0;
      vld_q <= '0;
      idx_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  // Last tag stage lines up with ROM data; decode it to the owner's strobe.
  always_comb begin
    bus.VALID_O = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.VALID_O[i] = vld_q[Lat-1] && (idx_q[Lat-1] == IdxW'(i));
    end
    bus.BUSY_O = |vld_q;
    bus.DATA_O = bus.ROM_RDATA_I;
  end

endmodule

// File: tb/tb_sprom_arbiter.sv
// Bench for sprom_arbiter: one instance per ROM latency, driven identically,
// compared against a queue-based reference model of grants and returns.
module tb_sprom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] addr [4];

  always #5 clk = ~clk;

  sprom_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REQ(4)) bus1 ();
  sprom_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REQ(4)) bus2 ();

  sprom_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .OUTPUT_REG("FALSE"), .NUM_REQ(4)) u_dut_l1 (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus1)
  );

  sprom_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .OUTPUT_REG("TRUE"), .NUM_REQ(4)) u_dut_l2 (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus2)
  );

  assign bus1.REQ_I  = req;
  assign bus2.REQ_I  = req;
  assign bus1.ADDR_I = {addr[3], addr[2], addr[1], addr[0]};
  assign bus2.ADDR_I = {addr[3], addr[2], addr[1], addr[0]};

  // SPROM models: latency 1 and latency 2 (extra output register).
  logic [15:0] mem [256];
  logic [15:0] r1_q, r2a_q, r2_q;
  always @(posedge clk) begin
    r1_q  <= mem[bus1.ROM_RADDR_O];
    r2a_q <= mem[bus2.ROM_RADDR_O];
    r2_q  <= r2a_q;
  end
  assign bus1.ROM_RDATA_I = r1_q;
  assign bus2.ROM_RDATA_I = r2_q;

  // Reference model: expected returns with the edge number at which each must appear.
  typedef struct {
    int         due;
    int         idx;
    logic [7:0] a;
  } ret_t;

  ret_t q1[$];
  ret_t q2[$];
  int   ptr_m  = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   count_en = 1'b0;
  int   cnt1 = 0;
  int   cnt2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_ret(input int lat, input logic [3:0] v, input logic [15:0] d,
                           input logic b);
    ret_t h;
    bit   have;
    bit   due_now;
    have = 1'b0;
    if (lat == 1) begin
      have = (q1.size() > 0);
      if (have) h = q1[0];
    end else begin
      have = (q2.size() > 0);
      if (have) h = q2[0];
    end
    due_now = have && (h.due == cyc);
    chk((lat == 1) ? "busy_l1" : "busy_l2", 32'(b), 32'(have));
    if (due_now) begin
      chk((lat == 1) ? "valid_l1" : "valid_l2", 32'(v), 32'd1 << h.idx);
      chk((lat == 1) ? "data_l1" : "data_l2", 32'(d), 32'(16'h00FF - 16'(h.a)));
      if (lat == 1) void'(q1.pop_front());
      else          void'(q2.pop_front());
    end else begin
      chk((lat == 1) ? "valid_l1" : "valid_l2", 32'(v), 32'd0);
    end
    if (count_en && (v != 4'd0)) begin
      if (lat == 1) cnt1++;
      else          cnt2++;
    end
  endtask

  // One clock: check grant outputs, cross the edge, update model, check returns.
  task automatic step();
    int          g;
    logic [31:0] ea;
    logic [31:0] er;
    g  = rst ? -1 : model_grant(req, ptr_m);
    ea = '0;
    er = '0;
    if (g >= 0) begin
      ea = 32'd1 << g;
      er = 32'(addr[g]);
    end
    #1;
    chk("ack_l1", 32'(bus1.ACK_O), ea);
    chk("ack_l2", 32'(bus2.ACK_O), ea);
    chk("raddr_l1", 32'(bus1.ROM_RADDR_O), er);
    chk("raddr_l2", 32'(bus2.ROM_RADDR_O), er);
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      q1.push_back('{cyc, g, addr[g]});
      q2.push_back('{cyc + 1, g, addr[g]});
      ptr_m = (g + 1) % 4;
    end
    #1;
    check_ret(1, bus1.VALID_O, bus1.DATA_O, bus1.BUSY_O);
    check_ret(2, bus2.VALID_O, bus2.DATA_O, bus2.BUSY_O);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q1.delete();
    q2.delete();
    ptr_m = 0;
    #1;
    chk("rst_valid_l1", 32'(bus1.VALID_O), 32'd0);
    chk("rst_valid_l2", 32'(bus2.VALID_O), 32'd0);
    chk("rst_busy_l1", 32'(bus1.BUSY_O), 32'd0);
    chk("rst_busy_l2", 32'(bus2.BUSY_O), 32'd0);
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h00FF - 16'(a);
    for (int i = 0; i < 4; i++) addr[i] = '0;
    #1;
    do_reset();

    // Single requester 2, consecutive addresses.
    req = 4'b0100;
    for (int a = 0; a < 3; a++) begin
      addr[2] = 8'(a);
      step();
    end
    drain(3);

    // Full contention after a fresh reset: rotation starts at 0.
    do_reset();
    for (int i = 0; i < 4; i++) addr[i] = 8'(i);
    req = 4'b1111;
    for (int i = 0; i < 12; i++) step();
    drain(3);

    // Pointer wrap: grant 3, then 0 and 3 both request.
    req = 4'b1000;
    step();
    req = 4'b1001;
    step();
    drain(3);

    // Reset one cycle after a grant to requester 1 discards the read.
    req = 4'b0010;
    addr[1] = 8'h33;
    step();
    req = 4'b0000;
    do_reset();
    req = 4'b1010;
    step();
    drain(3);

    // Idle stretch.
    drain(10);

    // Sustained throughput with address wrap.
    count_en = 1'b1;
    req = 4'b0001;
    for (int n = 0; n < 320; n++) begin
      addr[0] = 8'(n + 200);
      step();
    end
    drain(3);
    count_en = 1'b0;
    chk("pulses_l1", 32'(cnt1), 32'd320);
    chk("pulses_l2", 32'(cnt2), 32'd320);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      req = 4'($urandom);
      for (int i = 0; i < 4; i++) addr[i] = 8'($urandom);
      if ($urandom_range(0, 40) == 0) do_reset();
      else step();
    end
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
